// File: rtl/fake_rd_pkg.sv
// Shared types and constants for the fake RD serial data source.
package fake_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    FIN
  } state_t;

  localparam logic [1:0] PAT_LEGACY = 2'd0;
  localparam logic [1:0] PAT_OFFSET = 2'd1;
  localparam logic [1:0] PAT_LFSR   = 2'd2;
  localparam logic [1:0] PAT_ALT    = 2'd3;

  // Fibonacci taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rd_synchronizer.sv
// Two-flop synchroniser for one asynchronous control input.
module rd_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fake_rd_gen.sv
// Fake RD front end: streams triggered frames of parity-protected
// words on NCHAN serial lines with selectable test patterns.
module fake_rd_gen
  import fake_rd_pkg::*;
#(
  parameter int NCHAN      = 2,
  parameter int WORD_WIDTH = 12,
  parameter int MEM_SIZE   = 2048
) (
  input  logic             LOCAL_CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             TRIGGER,
  input  logic [1:0]       MODE,
  input  logic             ERR_INJECT,
  output logic             ENABLE_XFR,
  output logic [NCHAN-1:0] SERIAL_OUT,
  output logic             DONE,
  output logic [15:0]      XFR_COUNT
);

  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam int CW = $clog2(MEM_SIZE + 1);
  localparam logic [WORD_WIDTH-1:0] ALT =
    (WORD_WIDTH % 2 == 0) ? WORD_WIDTH'(16'hAAAA)
                          : WORD_WIDTH'(16'h5555);

  state_t                state_q;
  logic                  en_s;
  logic                  trig_s;
  logic                  trig_d;
  logic [BW-1:0]         bit_q;
  logic [CW-1:0]         word_q;
  logic [1:0]            mode_q;
  logic                  inj_q;
  logic                  start;
  logic                  last;
  logic                  next_word;
  logic                  shift;
  logic [1:0]            mode_sel;
  logic [WORD_WIDTH-1:0] n_nxt;
  logic [NCHAN-1:0]      msb_nxt;
  logic [NCHAN-1:0]      data_bit;
  logic [NCHAN-1:0]      par_bit;

  rd_synchronizer u_sync_en (
    .clk (LOCAL_CLK),
    .rst (RESET),
    .d   (ENABLE),
    .q   (en_s)
  );

  rd_synchronizer u_sync_trig (
    .clk (LOCAL_CLK),
    .rst (RESET),
    .d   (TRIGGER),
    .q   (trig_s)
  );

  always_ff @(posedge LOCAL_CLK or posedge RESET) begin
    if (RESET) trig_d <= 1'b0;
    else       trig_d <= trig_s;
  end

  assign start = (state_q == IDLE) && en_s
              && trig_s && !trig_d;
  assign last = (word_q == CW'(MEM_SIZE - 1));
  assign next_word = (state_q == PARITY) && en_s && !last;
  assign shift = (state_q == DATA) && en_s
              && (bit_q != '0);
  assign mode_sel = start ? MODE : mode_q;
  assign n_nxt = start ? '0
               : WORD_WIDTH'(word_q) + WORD_WIDTH'(1);

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    logic [15:0]           lfsr_q;
    logic [15:0]           lfsr_in;
    logic [WORD_WIDTH-1:0] pat;
    logic [WORD_WIDTH-2:0] rest_q;
    logic                  par_q;

    assign lfsr_in = start ? 16'(c + 1) : lfsr_step(lfsr_q);

    always_comb begin
      pat = n_nxt;
      unique case (mode_sel)
        PAT_LEGACY: pat = (c % 2 == 0) ? n_nxt : '0 - n_nxt;
        PAT_OFFSET: pat = n_nxt + WORD_WIDTH'(c);
        PAT_LFSR:   pat = lfsr_in[WORD_WIDTH-1:0];
        PAT_ALT:    pat = n_nxt[0] ? ~ALT : ALT;
      endcase
    end

    // MSB goes out on load; rest_q holds the bits still to send
    always_ff @(posedge LOCAL_CLK or posedge RESET) begin
      if (RESET) begin
        lfsr_q <= '0;
        rest_q <= '0;
        par_q  <= 1'b0;
      end else if (start || next_word) begin
        lfsr_q <= lfsr_in;
        rest_q <= pat[WORD_WIDTH-2:0];
        par_q  <= ~^pat;
      end else if (shift) begin
        rest_q <= {rest_q[WORD_WIDTH-3:0], 1'b0};
      end
    end

    assign msb_nxt[c]  = pat[WORD_WIDTH-1];
    assign data_bit[c] = rest_q[WORD_WIDTH-2];
    assign par_bit[c]  = par_q ^ ((c == 0) && inj_q
                       && (word_q == CW'(1)));
  end

  always_ff @(posedge LOCAL_CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      bit_q      <= '0;
      word_q     <= '0;
      mode_q     <= PAT_LEGACY;
      inj_q      <= 1'b0;
      ENABLE_XFR <= 1'b0;
      SERIAL_OUT <= '0;
      DONE       <= 1'b0;
      XFR_COUNT  <= '0;
    end else begin
      DONE <= 1'b0;
      if (state_q != IDLE && !en_s) begin
        state_q    <= IDLE;
        ENABLE_XFR <= 1'b0;
        SERIAL_OUT <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (start) begin
              state_q    <= DATA;
              bit_q      <= BW'(WORD_WIDTH - 1);
              word_q     <= '0;
              mode_q     <= MODE;
              inj_q      <= ERR_INJECT;
              ENABLE_XFR <= 1'b1;
              SERIAL_OUT <= msb_nxt;
            end
          end
          DATA: begin
            if (bit_q == '0) begin
              state_q    <= PARITY;
              SERIAL_OUT <= par_bit;
            end else begin
              bit_q      <= bit_q - 1'b1;
              SERIAL_OUT <= data_bit;
            end
          end
          PARITY: begin
            if (last) begin
              state_q    <= FIN;
              ENABLE_XFR <= 1'b0;
              SERIAL_OUT <= '0;
              DONE       <= 1'b1;
              XFR_COUNT  <= XFR_COUNT + 16'd1;
            end else begin
              state_q    <= DATA;
              word_q     <= word_q + 1'b1;
              bit_q      <= BW'(WORD_WIDTH - 1);
              SERIAL_OUT <= msb_nxt;
            end
          end
          FIN:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fake_rd_gen.sv
// Scoreboard bench for fake_rd_gen with 2 channels, 12-bit words,
// 4-word frames.
module tb_fake_rd_gen;

  localparam int NCHAN = 2;
  localparam int WW    = 12;
  localparam int MEM   = 4;
  localparam int FLEN  = MEM * (WW + 1);

  logic             LOCAL_CLK;
  logic             RESET;
  logic             ENABLE;
  logic             TRIGGER;
  logic [1:0]       MODE;
  logic             ERR_INJECT;
  logic             ENABLE_XFR;
  logic [NCHAN-1:0] SERIAL_OUT;
  logic             DONE;
  logic [15:0]      XFR_COUNT;

  fake_rd_gen #(
    .NCHAN      (NCHAN),
    .WORD_WIDTH (WW),
    .MEM_SIZE   (MEM)
  ) dut (
    .LOCAL_CLK  (LOCAL_CLK),
    .RESET      (RESET),
    .ENABLE     (ENABLE),
    .TRIGGER    (TRIGGER),
    .MODE       (MODE),
    .ERR_INJECT (ERR_INJECT),
    .ENABLE_XFR (ENABLE_XFR),
    .SERIAL_OUT (SERIAL_OUT),
    .DONE       (DONE),
    .XFR_COUNT  (XFR_COUNT)
  );

  initial LOCAL_CLK = 1'b0;
  always #5 LOCAL_CLK = ~LOCAL_CLK;

  int checks;
  int failures;
  int cyc;
  int lat;
  int done_cnt;
  int exp_count;
  logic to;
  logic [WW:0] cap [NCHAN][MEM];
  logic [WW:0] sb [$];

  task automatic push_frame(input logic [1:0] m, input logic inj);
    logic [15:0] l [NCHAN];
    logic [WW-1:0] w;
    logic p;
    for (int c = 0; c < NCHAN; c++) l[c] = 16'(c + 1);
    for (int k = 0; k < MEM; k++) begin
      for (int c = 0; c < NCHAN; c++) begin
        case (m)
          2'd0: w = (c % 2 == 0) ? WW'(k) : WW'(-k);
          2'd1: w = WW'(k + c);
          2'd2: w = l[c][WW-1:0];
          default: w = (k % 2 == 0) ? 12'hAAA : 12'h555;
        endcase
        p = ~^w;
        if (inj && c == 0 && k == 1) p = ~p;
        sb.push_back({w, p});
        l[c] = {l[c][14:0], l[c][15] ^ l[c][13] ^ l[c][12] ^ l[c][10]};
      end
    end
  endtask

  task automatic capture(input int hold, input int retrig,
                         input int tog);
    int w;
    int k;
    w = 0;
    cyc = 0;
    done_cnt = 0;
    for (int c = 0; c < NCHAN; c++)
      for (int j = 0; j < MEM; j++) cap[c][j] = '0;
    while (!ENABLE_XFR && w < 20) begin
      @(negedge LOCAL_CLK);
      w++;
      if (w == hold) TRIGGER = 1'b0;
    end
    lat = w;
    to = !ENABLE_XFR;
    while (ENABLE_XFR && cyc < 200) begin
      k = cyc / (WW + 1);
      for (int c = 0; c < NCHAN; c++)
        if (k < MEM) cap[c][k] = {cap[c][k][WW-1:0], SERIAL_OUT[c]};
      if (DONE) done_cnt++;
      cyc++;
      if (cyc == retrig) TRIGGER = 1'b1;
      if (cyc == tog) begin
        ERR_INJECT = !ERR_INJECT;
        MODE = ~MODE;
      end
      @(negedge LOCAL_CLK);
      w++;
      if (w == hold) TRIGGER = 1'b0;
    end
    repeat (3) begin
      if (DONE) done_cnt++;
      @(negedge LOCAL_CLK);
    end
  endtask

  task automatic test_reset();
    int act;
    act = 0;
    repeat (3) @(negedge LOCAL_CLK);
    checks++;
    if ({ENABLE_XFR, SERIAL_OUT, DONE} !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0",
               {ENABLE_XFR, SERIAL_OUT, DONE});
    end
    checks++;
    if (XFR_COUNT !== 16'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", XFR_COUNT);
    end
    RESET = 1'b0;
    repeat (10) begin
      @(negedge LOCAL_CLK);
      if (ENABLE_XFR) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL reset_idle got=%0d exp=0", act);
    end
  endtask

  task automatic test_legacy();
    logic [WW:0] e;
    MODE = 2'd0;
    ERR_INJECT = 1'b0;
    push_frame(2'd0, 1'b0);
    TRIGGER = 1'b1;
    capture(3, -1, -1);
    exp_count++;
    checks++;
    if (to || lat != 3) begin
      failures++;
      $display("FAIL legacy_latency got=%0d exp=3", lat);
    end
    checks++;
    if (cyc != FLEN) begin
      failures++;
      $display("FAIL legacy_len got=%0d exp=%0d", cyc, FLEN);
    end
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL legacy_done got=%0d exp=1", done_cnt);
    end
    checks++;
    if (XFR_COUNT !== 16'(exp_count)) begin
      failures++;
      $display("FAIL legacy_count got=%0d exp=%0d", XFR_COUNT, exp_count);
    end
    for (int k = 0; k < MEM; k++)
      for (int c = 0; c < NCHAN; c++) begin
        e = sb.pop_front();
        checks++;
        if (cap[c][k] !== e) begin
          failures++;
          $display("FAIL legacy_word c=%0d k=%0d got=%h exp=%h",
                   c, k, cap[c][k], e);
        end
      end
  endtask

  task automatic test_retrigger();
    logic [WW:0] e;
    int act;
    act = 0;
    push_frame(2'd0, 1'b0);
    TRIGGER = 1'b1;
    capture(3, 2 * (WW + 1), -1);
    exp_count++;
    checks++;
    if (cyc != FLEN || done_cnt != 1) begin
      failures++;
      $display("FAIL retrig_len got=%0d/%0d exp=%0d/1",
               cyc, done_cnt, FLEN);
    end
    for (int k = 0; k < MEM; k++)
      for (int c = 0; c < NCHAN; c++) begin
        e = sb.pop_front();
        checks++;
        if (cap[c][k] !== e) begin
          failures++;
          $display("FAIL retrig_word c=%0d k=%0d got=%h exp=%h",
                   c, k, cap[c][k], e);
        end
      end
    repeat (20) begin
      @(negedge LOCAL_CLK);
      if (ENABLE_XFR) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL retrig_held got=%0d exp=0", act);
    end
    TRIGGER = 1'b0;
    repeat (5) @(negedge LOCAL_CLK);
    push_frame(2'd0, 1'b0);
    TRIGGER = 1'b1;
    capture(3, -1, -1);
    exp_count++;
    checks++;
    if (to || cyc != FLEN) begin
      failures++;
      $display("FAIL retrig_new_len got=%0d exp=%0d", cyc, FLEN);
    end
    checks++;
    if (XFR_COUNT !== 16'(exp_count)) begin
      failures++;
      $display("FAIL retrig_count got=%0d exp=%0d", XFR_COUNT, exp_count);
    end
    for (int k = 0; k < MEM * NCHAN; k++) e = sb.pop_front();
  endtask

  task automatic test_abort();
    int w;
    int n;
    int dn;
    w = 0;
    n = 0;
    dn = 0;
    TRIGGER = 1'b1;
    while (!ENABLE_XFR && w < 20) begin
      @(negedge LOCAL_CLK);
      w++;
      if (w == 3) TRIGGER = 1'b0;
    end
    TRIGGER = 1'b0;
    repeat (WW + 1) @(negedge LOCAL_CLK);
    ENABLE = 1'b0;
    while (ENABLE_XFR && n < 10) begin
      @(negedge LOCAL_CLK);
      n++;
      if (DONE) dn++;
    end
    checks++;
    if (n < 2 || n > 3) begin
      failures++;
      $display("FAIL abort_delay got=%0d exp=2..3", n);
    end
    checks++;
    if (SERIAL_OUT !== '0) begin
      failures++;
      $display("FAIL abort_serial got=%b exp=0", SERIAL_OUT);
    end
    repeat (5) begin
      @(negedge LOCAL_CLK);
      if (DONE) dn++;
    end
    checks++;
    if (dn != 0) begin
      failures++;
      $display("FAIL abort_done got=%0d exp=0", dn);
    end
    checks++;
    if (XFR_COUNT !== 16'(exp_count)) begin
      failures++;
      $display("FAIL abort_count got=%0d exp=%0d", XFR_COUNT, exp_count);
    end
    ENABLE = 1'b1;
    repeat (5) @(negedge LOCAL_CLK);
  endtask

  task automatic test_lfsr();
    logic [WW:0] e;
    MODE = 2'd2;
    ERR_INJECT = 1'b0;
    push_frame(2'd2, 1'b0);
    TRIGGER = 1'b1;
    capture(3, -1, -1);
    exp_count++;
    checks++;
    if (to || cyc != FLEN || done_cnt != 1) begin
      failures++;
      $display("FAIL lfsr_len got=%0d/%0d exp=%0d/1", cyc, done_cnt, FLEN);
    end
    checks++;
    if (cap[0][0][WW:1] !== 12'h001 || cap[1][0][WW:1] !== 12'h002) begin
      failures++;
      $display("FAIL lfsr_seed got=%h/%h exp=001/002",
               cap[0][0][WW:1], cap[1][0][WW:1]);
    end
    for (int k = 0; k < MEM; k++)
      for (int c = 0; c < NCHAN; c++) begin
        e = sb.pop_front();
        checks++;
        if (cap[c][k] !== e) begin
          failures++;
          $display("FAIL lfsr_word c=%0d k=%0d got=%h exp=%h",
                   c, k, cap[c][k], e);
        end
      end
  endtask

  task automatic test_errinj();
    logic [WW:0] e;
    logic [WW:0] bad;
    bad = {12'h555, 1'b0};
    MODE = 2'd3;
    ERR_INJECT = 1'b1;
    push_frame(2'd3, 1'b1);
    TRIGGER = 1'b1;
    capture(3, -1, 20);
    exp_count++;
    checks++;
    if (cap[0][1] !== bad) begin
      failures++;
      $display("FAIL errinj_w1 got=%h exp=%h", cap[0][1], bad);
    end
    checks++;
    if (XFR_COUNT !== 16'(exp_count)) begin
      failures++;
      $display("FAIL errinj_count got=%0d exp=%0d", XFR_COUNT, exp_count);
    end
    for (int k = 0; k < MEM; k++)
      for (int c = 0; c < NCHAN; c++) begin
        e = sb.pop_front();
        checks++;
        if (cap[c][k] !== e) begin
          failures++;
          $display("FAIL errinj_word c=%0d k=%0d got=%h exp=%h",
                   c, k, cap[c][k], e);
        end
      end
    MODE = 2'd0;
    ERR_INJECT = 1'b0;
  endtask

  task automatic test_reset_mid();
    int act;
    act = 0;
    TRIGGER = 1'b1;
    repeat (3) @(negedge LOCAL_CLK);
    TRIGGER = 1'b0;
    repeat (10) @(negedge LOCAL_CLK);
    checks++;
    if (ENABLE_XFR !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_active got=%b exp=1", ENABLE_XFR);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if ({ENABLE_XFR, SERIAL_OUT, DONE} !== '0 || XFR_COUNT !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_outs got=%b/%0d exp=0/0",
               {ENABLE_XFR, SERIAL_OUT, DONE}, XFR_COUNT);
    end
    exp_count = 0;
    repeat (2) @(negedge LOCAL_CLK);
    RESET = 1'b0;
    repeat (30) begin
      @(negedge LOCAL_CLK);
      if (ENABLE_XFR) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL rstmid_idle got=%0d exp=0", act);
    end
    TRIGGER = 1'b1;
    capture(3, -1, -1);
    exp_count++;
    checks++;
    if (cyc != FLEN || XFR_COUNT !== 16'(exp_count)) begin
      failures++;
      $display("FAIL rstmid_frame got=%0d/%0d exp=%0d/%0d",
               cyc, XFR_COUNT, FLEN, exp_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_count = 0;
    RESET = 1'b1;
    ENABLE = 1'b1;
    TRIGGER = 1'b0;
    MODE = 2'd0;
    ERR_INJECT = 1'b0;
    test_reset();
    test_legacy();
    test_retrigger();
    test_abort();
    test_lfsr();
    test_errinj();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
